vx_dma_chan_unit: RTL and testbench

Multi-channel successor to the per-warp single-DMA issue unit. It sits in the SFU path beside the CSR unit and decodes the DMA instructions: SET_DST, SET_SRC, SET_SIZE, TRIGGER and WAIT. Each warp may have up to `NUM_SLOTS` outstanding transfers, and requests reach `VX_dma_engine` through a buffered queue with real backpressure. WAIT supports both per-transfer and wait-all semantics, and the unit drives a per-warp stall mask to the scheduler.

---
 rtl/vx_dma_chan_unit_pkg.sv | 30 +++
 rtl/vx_dma_chan_unit_fifo.sv | 55 +++++
 rtl/vx_dma_chan_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_vx_dma_chan_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dma_chan_unit_pkg.sv
// Shared definitions for the DMA channel unit: warp geometry, bus tag width,
// DMA opcode encoding, the wait-all sentinel and the tag helper.
package vx_dma_chan_unit_pkg;

  localparam int NUM_WARPS = 4;
  localparam int NW_WIDTH  = 2;
  localparam int XLEN      = 32;
  localparam int BUS_TAG_W = 8;

  // rs1 value that turns WAIT into wait-for-all-pending.
  localparam logic [XLEN-1:0] DMA_WAIT_ALL = '1;

  typedef logic [BUS_TAG_W-1:0] dma_tag_t;

  typedef enum logic [2:0] {
    DMA_OP_SET_DST = 3'd0,
    DMA_OP_SET_SRC = 3'd1,
    DMA_OP_SET_SIZE = 3'd2,
    DMA_OP_TRIGGER = 3'd3,
    DMA_OP_WAIT    = 3'd4
  } dma_op_e;

  // Tag layout is {wid, slot}, zero-extended to the bus tag width.
  function automatic dma_tag_t dma_make_tag(input logic [NW_WIDTH-1:0] wid,
                                            input dma_tag_t slot,
                                            input int slot_bits);
    return (dma_tag_t'(wid) << slot_bits) | slot;
  endfunction

endpackage

// File: rtl/vx_dma_chan_unit_fifo.sv
// Synchronous FIFO used both as the DMA request queue and as the 2-entry
// result elastic buffer. Output is taken straight from storage, so a push
// at cycle N is visible on dout/!empty at N+1. full/empty come from the
// registered count only, so a push into a full queue is refused even when
// a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, empty, full.
module vx_dma_chan_unit_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] din,
  input  logic             pop,
  output logic [DATAW-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vx_dma_chan_unit.sv
// Multi-slot DMA issue unit. Decodes SET_DST/SET_SRC/SET_SIZE/TRIGGER/WAIT,
// keeps per-warp config and pending-slot state, queues requests toward the
// DMA engine and drives a registered per-warp stall mask.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   execute_*            instruction beat (valid/ready, op, wid, rd, wb, dir,
//                        rs1 per lane; only lane 0 is decoded)
//   result_*             writeback beat (valid/ready, wid, rd, wb, data)
//   req_*                request to the DMA engine (valid/ready, src, dst,
//                        size, dir, tag)
//   rsp_valid/rsp_tag    completion from the engine; rsp_ready is always 1
//   warp_stall_mask      per-warp stall toward the scheduler
//   perf_*               32-bit counters, only when DMA_CHAN_PERF_EN is defined
module vx_dma_chan_unit
  import vx_dma_chan_unit_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_LANES   = 1,
  parameter int    NUM_SLOTS   = 4,
  parameter int    REQ_DEPTH   = 4,
  parameter int    ADDR_WIDTH  = 32,
  parameter int    SIZE_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                execute_valid,
  output logic                                execute_ready,
  input  logic [2:0]                          execute_op,
  input  logic [NW_WIDTH-1:0]                 execute_wid,
  input  logic [4:0]                          execute_rd,
  input  logic                                execute_wb,
  input  logic                                execute_dir,
  input  logic [NUM_LANES-1:0][XLEN-1:0]      execute_rs1_data,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic [NW_WIDTH-1:0]                 result_wid,
  output logic [4:0]                          result_rd,
  output logic                                result_wb,
  output logic [NUM_LANES-1:0][XLEN-1:0]      result_data,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [ADDR_WIDTH-1:0]               req_src,
  output logic [ADDR_WIDTH-1:0]               req_dst,
  output logic [SIZE_WIDTH-1:0]               req_size,
  output logic                                req_dir,
  output logic [BUS_TAG_W-1:0]                req_tag,
  input  logic                                rsp_valid,
  input  logic [BUS_TAG_W-1:0]                rsp_tag,
  output logic                                rsp_ready,
  output logic [NUM_WARPS-1:0]                warp_stall_mask
`ifdef DMA_CHAN_PERF_EN
  ,
  output logic [31:0]                         perf_dma_issued,
  output logic [31:0]                         perf_stall_cycles,
  output logic [31:0]                         perf_trig_blocked
`endif
);

  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int TAG_W     = NW_WIDTH + SLOT_BITS;
  localparam int REQ_W     = 2 * ADDR_WIDTH + SIZE_WIDTH + 1 + BUS_TAG_W;
  localparam int RES_W     = NW_WIDTH + 5 + 1 + NUM_LANES * XLEN;

  if (TAG_W > BUS_TAG_W) begin : g_tag_chk
    $error("vx_dma_chan_unit: tag width exceeds bus tag width");
  end
  if (NUM_SLOTS < 2 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_slot_chk
    $error("vx_dma_chan_unit: NUM_SLOTS must be a power of two >= 2");
  end
  if (REQ_DEPTH < 2) begin : g_depth_chk
    $error("vx_dma_chan_unit: REQ_DEPTH must be >= 2");
  end

  logic [NUM_WARPS-1:0][NUM_SLOTS-1:0] pending, pending_n, wait_mask, wait_n;
  logic [NUM_WARPS-1:0]                stall_n;
  logic [ADDR_WIDTH-1:0]               cfg_src  [NUM_WARPS];
  logic [ADDR_WIDTH-1:0]               cfg_dst  [NUM_WARPS];
  logic [SIZE_WIDTH-1:0]               cfg_size [NUM_WARPS];

  logic [XLEN-1:0]             rs1;
  logic                        is_trig, is_wait, has_free;
  logic [SLOT_BITS-1:0]        alloc_slot;
  dma_tag_t                    trig_tag;
  logic                        exec_fire, trig_fire, wait_fire;
  logic                        q_full, q_empty, r_full, r_empty;
  logic [REQ_W-1:0]            q_dout;
  logic [RES_W-1:0]            r_dout;
  logic [NUM_LANES-1:0][XLEN-1:0] res_data;
  logic [NW_WIDTH-1:0]         rsp_wid;
  logic [SLOT_BITS-1:0]        rsp_slot;
  logic                        rsp_hit;
  logic [NUM_SLOTS-1:0]        wait_sel;
  logic                        unused_bits;

  assign rs1     = execute_rs1_data[0];
  assign is_trig = (execute_op == DMA_OP_TRIGGER);
  assign is_wait = (execute_op == DMA_OP_WAIT);

  // Lowest free slot, from the registered pending state.
  always_comb begin
    has_free   = 1'b0;
    alloc_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!pending[execute_wid][i]) begin
        has_free   = 1'b1;
        alloc_slot = SLOT_BITS'(i);
      end
    end
  end

  assign trig_tag      = dma_make_tag(execute_wid, dma_tag_t'(alloc_slot), SLOT_BITS);
  assign execute_ready = !r_full && (!is_trig || (has_free && !q_full));
  assign exec_fire     = execute_valid && execute_ready;
  assign trig_fire     = exec_fire && is_trig;
  assign wait_fire     = exec_fire && is_wait;

  assign rsp_ready = 1'b1;
  assign rsp_wid   = rsp_tag[TAG_W-1:SLOT_BITS];
  assign rsp_slot  = rsp_tag[SLOT_BITS-1:0];
  assign rsp_hit   = pending[rsp_wid][rsp_slot];

  assign wait_sel = (rs1 == DMA_WAIT_ALL) ? pending[execute_wid]
                  : (NUM_SLOTS'(1) << rs1[SLOT_BITS-1:0]) & pending[execute_wid];

  // Response clears first, so a WAIT landing with the response of its own
  // slot masks against the already-cleared pending bit and never stalls.
  always_comb begin
    pending_n = pending;
    wait_n    = wait_mask;
    if (rsp_valid) begin
      pending_n[rsp_wid][rsp_slot] = 1'b0;
      wait_n[rsp_wid][rsp_slot]    = 1'b0;
    end
    if (trig_fire) pending_n[execute_wid][alloc_slot] = 1'b1;
    if (wait_fire) wait_n[execute_wid] = wait_sel & pending_n[execute_wid];
    for (int w = 0; w < NUM_WARPS; w++) begin
      stall_n[w] = |(wait_n[w] & pending_n[w]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending         <= '0;
      wait_mask       <= '0;
      warp_stall_mask <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        cfg_src[w]  <= '0;
        cfg_dst[w]  <= '0;
        cfg_size[w] <= '0;
      end
    end else begin
      pending         <= pending_n;
      wait_mask       <= wait_n;
      warp_stall_mask <= stall_n;
      if (exec_fire) begin
        case (execute_op)
          DMA_OP_SET_DST:  cfg_dst[execute_wid]  <= ADDR_WIDTH'(rs1);
          DMA_OP_SET_SRC:  cfg_src[execute_wid]  <= ADDR_WIDTH'(rs1);
          DMA_OP_SET_SIZE: cfg_size[execute_wid] <= SIZE_WIDTH'(rs1);
          default: ;
        endcase
      end
    end
  end

  vx_dma_chan_unit_fifo #(.DATAW(REQ_W), .DEPTH(REQ_DEPTH)) req_queue (
    .clk   (clk),
    .reset (reset),
    .push  (trig_fire),
    .din   ({cfg_src[execute_wid], cfg_dst[execute_wid], cfg_size[execute_wid],
             execute_dir, trig_tag}),
    .pop   (req_valid && req_ready),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full)
  );

  assign req_valid = !q_empty;
  assign {req_src, req_dst, req_size, req_dir, req_tag} = q_dout;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      res_data[l] = is_trig ? XLEN'(trig_tag) : '0;
    end
  end

  vx_dma_chan_unit_fifo #(.DATAW(RES_W), .DEPTH(2)) res_buf (
    .clk   (clk),
    .reset (reset),
    .push  (exec_fire),
    .din   ({execute_wid, execute_rd, execute_wb, res_data}),
    .pop   (result_valid && result_ready),
    .dout  (r_dout),
    .empty (r_empty),
    .full  (r_full)
  );

  assign result_valid = !r_empty;
  assign {result_wid, result_rd, result_wb, result_data} = r_dout;

  assign unused_bits = ^{execute_rs1_data, rsp_tag};

`ifdef DMA_CHAN_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dma_issued   <= '0;
      perf_stall_cycles <= '0;
      perf_trig_blocked <= '0;
    end else begin
      if (req_valid && req_ready) perf_dma_issued <= perf_dma_issued + 32'd1;
      if (|warp_stall_mask)       perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (execute_valid && is_trig && !execute_ready)
        perf_trig_blocked <= perf_trig_blocked + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Stale completions (e.g. after a reset) are dropped; flag them in sim.
  always @(posedge clk) begin
    if (!reset && rsp_valid) begin
      assert (rsp_hit)
        else $warning("%s: dma response for non-pending tag 0x%0h ignored", INSTANCE_ID, rsp_tag);
    end
  end
`endif

endmodule

// File: tb/tb_vx_dma_chan_unit.sv
module tb_vx_dma_chan_unit;
  import vx_dma_chan_unit_pkg::*;

  localparam int LANES = 2;

  logic clk = 1'b0;
  logic reset;
  logic execute_valid, execute_ready, execute_wb, execute_dir;
  logic [2:0] execute_op;
  logic [NW_WIDTH-1:0] execute_wid;
  logic [4:0] execute_rd;
  logic [LANES-1:0][31:0] execute_rs1_data;
  logic result_valid, result_ready, result_wb;
  logic [NW_WIDTH-1:0] result_wid;
  logic [4:0] result_rd;
  logic [LANES-1:0][31:0] result_data;
  logic req_valid, req_ready, req_dir;
  logic [31:0] req_src, req_dst;
  logic [15:0] req_size;
  logic [7:0] req_tag, rsp_tag;
  logic rsp_valid, rsp_ready;
  logic [NUM_WARPS-1:0] warp_stall_mask;
`ifdef DMA_CHAN_PERF_EN
  logic [31:0] perf_dma_issued, perf_stall_cycles, perf_trig_blocked;
`endif

  vx_dma_chan_unit #(.INSTANCE_ID("dut"), .NUM_LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .execute_valid(execute_valid), .execute_ready(execute_ready),
    .execute_op(execute_op), .execute_wid(execute_wid), .execute_rd(execute_rd),
    .execute_wb(execute_wb), .execute_dir(execute_dir),
    .execute_rs1_data(execute_rs1_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_wid(result_wid), .result_rd(result_rd), .result_wb(result_wb),
    .result_data(result_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_dst(req_dst), .req_size(req_size), .req_dir(req_dir), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .warp_stall_mask(warp_stall_mask)
`ifdef DMA_CHAN_PERF_EN
    , .perf_dma_issued(perf_dma_issued), .perf_stall_cycles(perf_stall_cycles),
    .perf_trig_blocked(perf_trig_blocked)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] size;
    logic        dir;
    logic [7:0]  tag;
    int          c;
  } req_rec_t;

  req_rec_t    req_log[$];
  logic [31:0] res_l0[$];
  logic [31:0] res_l1[$];
  int          res_cyc[$];

  always @(posedge clk) begin
    if (!reset && req_valid && req_ready)
      req_log.push_back('{req_src, req_dst, req_size, req_dir, req_tag, cyc});
    if (!reset && result_valid && result_ready) begin
      res_l0.push_back(result_data[0]);
      res_l1.push_back(result_data[1]);
      res_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic clear_logs();
    req_log.delete();
    res_l0.delete();
    res_l1.delete();
    res_cyc.delete();
  endtask

  task automatic drive(input logic [2:0] op, input int wid, input logic [31:0] rs1,
                       input logic dir);
    execute_valid = 1'b1;
    execute_op    = op;
    execute_wid   = wid[NW_WIDTH-1:0];
    execute_rd    = 5'd7;
    execute_wb    = (op == DMA_OP_TRIGGER);
    execute_dir   = dir;
    for (int l = 0; l < LANES; l++) execute_rs1_data[l] = rs1;
  endtask

  task automatic issue(input logic [2:0] op, input int wid, input logic [31:0] rs1,
                       input logic dir, output int fcyc);
    int n;
    @(negedge clk);
    drive(op, wid, rs1, dir);
    #1;
    n = 0;
    while (!execute_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (execute_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_timeout op=%0d wid=%0d: ready=%0b required=1", op, wid, execute_ready);
    end
    @(posedge clk);
    fcyc = cyc;
    #1 execute_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] tag);
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_tag   = tag;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    execute_valid = 1'b0; execute_op = DMA_OP_SET_DST; execute_wid = '0;
    execute_rd = '0; execute_wb = 1'b0; execute_dir = 1'b0; execute_rs1_data = '0;
    result_ready = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %0b want 0", req_valid); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_result_valid: got %0b want 0", result_valid); end
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL rst_stall: got %b want 0000", warp_stall_mask); end
    total++; if (execute_ready !== 1'b1) begin bad++; $display("FAIL rst_exec_ready: got %0b want 1", execute_ready); end
  endtask

  task automatic test_single();
    int f, ft;
    clear_logs();
    req_ready = 1'b1;
    issue(DMA_OP_SET_SRC, 2, 32'h1000, 1'b0, f);
    issue(DMA_OP_SET_DST, 2, 32'h20, 1'b0, f);
    issue(DMA_OP_SET_SIZE, 2, 32'd64, 1'b0, f);
    issue(DMA_OP_TRIGGER, 2, 32'h0, 1'b1, ft);
    repeat (3) @(negedge clk);
    total++;
    if (res_l0.size() !== 4) begin bad++; $display("FAIL single_res_count: got %0d want 4", res_l0.size()); end
    else begin
      total++; if (res_l0[3] !== 32'h08) begin bad++; $display("FAIL single_rd_lane0: got %h want 00000008", res_l0[3]); end
      total++; if (res_l1[3] !== 32'h08) begin bad++; $display("FAIL single_rd_lane1: got %h want 00000008", res_l1[3]); end
      total++; if (res_l0[0] !== 32'h0) begin bad++; $display("FAIL single_set_rd: got %h want 0", res_l0[0]); end
      total++; if (res_cyc[3] !== ft + 1) begin bad++; $display("FAIL single_res_latency: got %0d want %0d", res_cyc[3], ft + 1); end
    end
    total++;
    if (req_log.size() !== 1) begin bad++; $display("FAIL single_req_count: got %0d want 1", req_log.size()); end
    else begin
      total++; if (req_log[0].src !== 32'h1000) begin bad++; $display("FAIL single_src: got %h want 00001000", req_log[0].src); end
      total++; if (req_log[0].dst !== 32'h20) begin bad++; $display("FAIL single_dst: got %h want 00000020", req_log[0].dst); end
      total++; if (req_log[0].size !== 16'd64) begin bad++; $display("FAIL single_size: got %0d want 64", req_log[0].size); end
      total++; if (req_log[0].dir !== 1'b1) begin bad++; $display("FAIL single_dir: got %0b want 1", req_log[0].dir); end
      total++; if (req_log[0].tag !== 8'h08) begin bad++; $display("FAIL single_tag: got %h want 08", req_log[0].tag); end
      total++; if (req_log[0].c !== ft + 1) begin bad++; $display("FAIL single_req_latency: got %0d want %0d", req_log[0].c, ft + 1); end
    end
    send_rsp(8'h08);
  endtask

  task automatic test_slot_alloc();
    int f;
    logic [31:0] exp_rd [5];
    exp_rd = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd1};
    clear_logs();
    for (int i = 0; i < 4; i++) issue(DMA_OP_TRIGGER, 0, 32'h0, 1'b0, f);
    @(negedge clk);
    drive(DMA_OP_TRIGGER, 0, 32'h0, 1'b0);
    #1;
    total++; if (execute_ready !== 1'b0) begin bad++; $display("FAIL alloc_full_blocked: got %0b want 0", execute_ready); end
    @(negedge clk);
    rsp_valid = 1'b1; rsp_tag = 8'h01;
    #1;
    total++; if (execute_ready !== 1'b0) begin bad++; $display("FAIL alloc_rsp_same_cycle: got %0b want 0", execute_ready); end
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    total++; if (execute_ready !== 1'b1) begin bad++; $display("FAIL alloc_after_rsp: got %0b want 1", execute_ready); end
    @(posedge clk);
    #1 execute_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (res_l0.size() !== 5) begin bad++; $display("FAIL alloc_res_count: got %0d want 5", res_l0.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (res_l0[i] !== exp_rd[i]) begin bad++; $display("FAIL alloc_rd[%0d]: got %h want %h", i, res_l0[i], exp_rd[i]); end
      end
    end
    for (int i = 0; i < 4; i++) send_rsp(8'(i));
  endtask

  task automatic test_queue_full();
    int f;
    logic [7:0] exp_tag [5];
    exp_tag = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h01};
    clear_logs();
    req_ready = 1'b0;
    for (int w = 0; w < 4; w++) issue(DMA_OP_TRIGGER, w, 32'h0, 1'b0, f);
    @(negedge clk);
    drive(DMA_OP_TRIGGER, 0, 32'h0, 1'b0);
    #1;
    total++; if (execute_ready !== 1'b0) begin bad++; $display("FAIL qfull_blocked: got %0b want 0", execute_ready); end
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL qfull_req_valid: got %0b want 1", req_valid); end
    req_ready = 1'b1;
    #1;
    total++; if (execute_ready !== 1'b0) begin bad++; $display("FAIL qfull_pop_same_cycle: got %0b want 0", execute_ready); end
    @(posedge clk);
    #1;
    total++; if (execute_ready !== 1'b1) begin bad++; $display("FAIL qfull_after_pop: got %0b want 1", execute_ready); end
    @(posedge clk);
    #1 execute_valid = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (req_log.size() !== 5) begin bad++; $display("FAIL qfull_req_count: got %0d want 5", req_log.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (req_log[i].tag !== exp_tag[i]) begin bad++; $display("FAIL qfull_tag[%0d]: got %h want %h", i, req_log[i].tag, exp_tag[i]); end
        total++;
        if (req_log[i].c !== req_log[0].c + i) begin bad++; $display("FAIL qfull_cycle[%0d]: got %0d want %0d", i, req_log[i].c, req_log[0].c + i); end
      end
    end
    for (int i = 0; i < 5; i++) send_rsp(exp_tag[i]);
  endtask

  task automatic test_wait_all();
    int f;
    clear_logs();
    req_ready = 1'b1;
    issue(DMA_OP_TRIGGER, 1, 32'h0, 1'b0, f);
    issue(DMA_OP_TRIGGER, 1, 32'h0, 1'b0, f);
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL waitall_pre: got %b want 0000", warp_stall_mask); end
    issue(DMA_OP_WAIT, 1, 32'hFFFF_FFFF, 1'b0, f);
    total++; if (warp_stall_mask !== 4'b0010) begin bad++; $display("FAIL waitall_stall: got %b want 0010", warp_stall_mask); end
    send_rsp(8'h04);
    total++; if (warp_stall_mask !== 4'b0010) begin bad++; $display("FAIL waitall_after_slot0: got %b want 0010", warp_stall_mask); end
    send_rsp(8'h05);
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL waitall_after_slot1: got %b want 0000", warp_stall_mask); end
  endtask

  task automatic test_wait_single();
    int f;
    clear_logs();
    issue(DMA_OP_TRIGGER, 3, 32'h0, 1'b0, f);
    issue(DMA_OP_WAIT, 3, 32'd3, 1'b0, f);
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL wait_nonpending: got %b want 0000", warp_stall_mask); end
    issue(DMA_OP_WAIT, 3, 32'd0, 1'b0, f);
    total++; if (warp_stall_mask !== 4'b1000) begin bad++; $display("FAIL wait_slot0: got %b want 1000", warp_stall_mask); end
    send_rsp(8'h0C);
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL wait_slot0_done: got %b want 0000", warp_stall_mask); end
    issue(DMA_OP_TRIGGER, 3, 32'h0, 1'b0, f);
    @(negedge clk);
    drive(DMA_OP_WAIT, 3, 32'd0, 1'b0);
    rsp_valid = 1'b1; rsp_tag = 8'h0C;
    #1;
    total++; if (execute_ready !== 1'b1) begin bad++; $display("FAIL wait_rsp_ready: got %0b want 1", execute_ready); end
    @(posedge clk);
    #1;
    execute_valid = 1'b0; rsp_valid = 1'b0;
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL wait_rsp_same_cycle: got %b want 0000", warp_stall_mask); end
  endtask

  task automatic test_reset_mid();
    int f;
    clear_logs();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(DMA_OP_TRIGGER, 2, 32'h0, 1'b0, f);
    issue(DMA_OP_WAIT, 2, 32'hFFFF_FFFF, 1'b0, f);
    total++; if (warp_stall_mask !== 4'b0100) begin bad++; $display("FAIL rmid_pre_stall: got %b want 0100", warp_stall_mask); end
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_req_valid: got %0b want 1", req_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req_valid: got %0b want 0", req_valid); end
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL rmid_stall: got %b want 0000", warp_stall_mask); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rmid_result_valid: got %0b want 0", result_valid); end
    @(negedge clk);
    reset = 1'b0;
    req_ready = 1'b1;
    clear_logs();
    send_rsp(8'h09);
    total++; if (warp_stall_mask !== 4'b0000) begin bad++; $display("FAIL rmid_stale_stall: got %b want 0000", warp_stall_mask); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale_req: got %0b want 0", req_valid); end
    issue(DMA_OP_TRIGGER, 2, 32'h0, 1'b0, f);
    repeat (3) @(negedge clk);
    total++;
    if (req_log.size() !== 1) begin bad++; $display("FAIL rmid_req_count: got %0d want 1", req_log.size()); end
    else begin
      total++; if (req_log[0].tag !== 8'h08) begin bad++; $display("FAIL rmid_realloc_tag: got %h want 08", req_log[0].tag); end
      total++; if (req_log[0].src !== 32'h0) begin bad++; $display("FAIL rmid_cfg_cleared: got %h want 0", req_log[0].src); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_slot_alloc();
    test_queue_full();
    test_wait_all();
    test_wait_single();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
